muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit that sits beside the ALU in the execute stage. It sequences a shared 33-bit add/subtract datapath over 32 cycles to implement unsigned MUL, MULHU, DIVU and REMU. While an operation is in progress it stalls the pipeline. It returns the result during the single cycle in which the execute stage is allowed to advance into memory.

## Interface
- No parameters; operand width fixed at 32.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- StartE  in  1  a multiply/divide instruction is present in execute; held high while stalled.
- OpE  in  2  operation: 00 MUL (low 32 bits), 01 MULHU (high 32 bits), 10 DIVU (quotient), 11 REMU (remainder).
- SrcAE  in  32  operand A (multiplicand / dividend).
- SrcBE  in  32  operand B (multiplier / divisor).
- FlushE  in  1  execute-stage flush; aborts any operation.
- StallE  out  1  holds the fetch, decode and execute pipeline registers.
- DoneE  out  1  one-cycle pulse; MulDivResultE is valid.
- MulDivResultE  out  32  result, muxed by the execute stage in place of the ALU result when DoneE=1.

## Operation
- States: IDLE, CALC, DONE. Reset value is IDLE, with StallE=0, DoneE=0, MulDivResultE=0, and counter, op and internal registers all 0.
- IDLE with StartE=1 and FlushE=0:
  - Latch OpE, A and B.
  - Initialise the 64-bit work register: {32'h0, A} for both multiply and divide.
  - Set count=0.
- IDLE to CALC on that accept.
- IDLE to DONE on accept when the op is DIVU/REMU and B==0 (divide by zero).
- Multiply step in CALC, one per cycle:
  - If work[0]=1, form the 33-bit sum {carry, work[63:32] + B}; otherwise the sum is {0, work[63:32]}.
  - work <= {sum, work[31:1]}.
- Divide step in CALC (restoring), one per cycle:
  - Shift: t = {work[62:0], 0}.
  - Compute the 33-bit difference d = t[63:32] - B.
  - If there is no borrow: work <= {d[31:0], t[31:1], 1}.
  - Otherwise: work <= t, with bit0=0.
- count increments each CALC cycle. CALC goes to DONE when count==31, after the 32nd step; the 5-bit counter wraps to 0 there.
- Result selection in DONE:
  - MUL: work[31:0].
  - MULHU: work[63:32].
  - DIVU: work[31:0].
  - REMU: work[63:32].
- Divide-by-zero results: DIVU returns 0xFFFFFFFF; REMU returns A (RISC-V semantics).
- DONE always goes to IDLE. StartE is not sampled in DONE; the instruction leaves execute that cycle.
- MulDivResultE is registered when entering DONE and holds its value until the next DONE.
- FlushE=1 in any state forces IDLE on the next edge. DoneE is suppressed that cycle and the work register is not updated.

## Timing
- Accept cycle T: the IDLE cycle in which StartE=1.
- Normal operation:
  - CALC occupies T+1 .. T+32.
  - DONE is T+33, so the total latency is 33 cycles after accept.
- Divide by zero: DONE at T+1.
- StallE = (IDLE & StartE & ~FlushE) | CALC, plus (IDLE & divide-by-zero accept), combinationally.
  - StallE is high from T through the last cycle before DONE.
  - StallE is low in DONE.
  - StallE is low whenever FlushE=1.
- DoneE = (state==DONE). It is high for exactly one cycle per accepted operation.
- Back-to-back operations: a second StartE in the cycle after DONE is accepted normally. There are no bubbles beyond DONE.
- Reset mid-operation: asynchronous return to IDLE; all outputs go to 0 immediately.

## Test plan
- MUL 7 x 6:
  - StartE at T gives StallE high T..T+32.
  - DoneE at T+33 with MulDivResultE=0x0000002A.
  - StallE=0 at T+33.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF gives MulDivResultE=0xFFFFFFFE. MUL of the same operands gives 0x00000001.
- DIVU 100 / 7 gives 0x0000000E. REMU 100 / 7 gives 0x00000002. DIVU 5 / 9 gives 0, and REMU gives 5.
- DIVU 0x1234 / 0 gives DoneE at T+1 with result 0xFFFFFFFF. REMU 0x1234 / 0 gives 0x00001234 with DoneE at T+1.
- Flush during CALC:
  - Setup: FlushE pulsed at T+10 of a MUL.
  - StallE must be 0 at T+10, the state must be IDLE at T+11, and no DoneE may occur.
  - A new MUL 3 x 3 accepted at T+11 must return 9 at T+44.
- rst low at T+20 of a DIVU:
  - StallE, DoneE and MulDivResultE must be 0 immediately.
  - After release, a DIVU 9 / 3 must complete normally with result 3.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit on a shared 33-bit add/sub datapath, one bit per cycle.
// Latency: 33 cycles after accept (32 CALC steps + DONE); divide-by-zero finishes in 1 cycle.
// Backpressure: StallE holds the front-end while busy; DoneE pulses once when the result may advance.
// Ports: clk/rst (async active-low); StartE/OpE/SrcAE/SrcBE request; FlushE aborts;
//        StallE, DoneE, MulDivResultE (registered, held until the next DONE).
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        StartE,
  input  logic [1:0]  OpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        FlushE,
  output logic        StallE,
  output logic        DoneE,
  output logic [31:0] MulDivResultE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  op, op_nxt;
  logic [31:0] b_reg, b_nxt;
  logic [63:0] work, work_nxt;
  logic [4:0]  count, count_nxt;
  logic [31:0] result, result_nxt;

  logic        accept;
  logic        div_by_zero;
  logic [32:0] mul_sum;
  logic [63:0] div_t;
  logic [32:0] div_d;
  logic [63:0] step_work;

  assign accept      = (state == IDLE) && StartE && !FlushE;
  assign div_by_zero = OpE[1] && (SrcBE == 32'h0);

  // One iteration of the shared datapath. Multiply: conditional add into the
  // upper half, then shift right with the carry landing in bit 63. Divide:
  // restoring step, quotient bits shift into the low half, remainder on top.
  always_comb begin
    mul_sum = work[0] ? ({1'b0, work[63:32]} + {1'b0, b_reg}) : {1'b0, work[63:32]};
    div_t   = {work[62:0], 1'b0};
    div_d   = {1'b0, div_t[63:32]} - {1'b0, b_reg};
    if (op[1]) begin
      step_work = div_d[32] ? div_t : {div_d[31:0], div_t[31:1], 1'b1};
    end else begin
      step_work = {mul_sum, work[31:1]};
    end
  end

  always_comb begin
    state_nxt  = state;
    op_nxt     = op;
    b_nxt      = b_reg;
    work_nxt   = work;
    count_nxt  = count;
    result_nxt = result;
    case (state)
      IDLE: begin
        if (accept) begin
          op_nxt    = OpE;
          b_nxt     = SrcBE;
          work_nxt  = {32'h0, SrcAE};
          count_nxt = 5'd0;
          if (div_by_zero) begin
            // RISC-V semantics: quotient all ones, remainder is the dividend.
            state_nxt  = DONE;
            result_nxt = OpE[0] ? SrcAE : 32'hFFFF_FFFF;
          end else begin
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        work_nxt  = step_work;
        count_nxt = count + 5'd1;
        if (count == 5'd31) begin
          state_nxt = DONE;
          // op[0] picks the upper half: MULHU and REMU; MUL/DIVU use the lower half.
          result_nxt = op[0] ? step_work[63:32] : step_work[31:0];
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // A flush abandons the instruction outright: no datapath update, no result.
    if (FlushE) begin
      state_nxt  = IDLE;
      op_nxt     = op;
      b_nxt      = b_reg;
      work_nxt   = work;
      count_nxt  = 5'd0;
      result_nxt = result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op     <= 2'b00;
      b_reg  <= 32'h0;
      work   <= 64'h0;
      count  <= 5'd0;
      result <= 32'h0;
    end else begin
      state  <= state_nxt;
      op     <= op_nxt;
      b_reg  <= b_nxt;
      work   <= work_nxt;
      count  <= count_nxt;
      result <= result_nxt;
    end
  end

  // Gated by rst so every output reads 0 while reset is asserted, even with
  // StartE still high from the pipeline.
  assign StallE        = rst && !FlushE && (((state == IDLE) && StartE) || (state == CALC));
  assign DoneE         = (state == DONE) && !FlushE;
  assign MulDivResultE = result;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        StartE;
  logic [1:0]  OpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        FlushE;
  logic        StallE;
  logic        DoneE;
  logic [31:0] MulDivResultE;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk           (clk),
    .rst           (rst),
    .StartE        (StartE),
    .OpE           (OpE),
    .SrcAE         (SrcAE),
    .SrcBE         (SrcBE),
    .FlushE        (FlushE),
    .StallE        (StallE),
    .DoneE         (DoneE),
    .MulDivResultE (MulDivResultE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents a request in the cycle following the next rising edge (cycle T).
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    StartE = 1'b1;
    OpE    = op;
    SrcAE  = a;
    SrcBE  = b;
  endtask

  // Called in cycle T (inputs already driven). Counts cycles to DoneE, checks
  // StallE stays high before it, then checks latency, StallE low and the result.
  // Returns at the falling edge of the DONE cycle, StartE left high.
  task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat);
    int cyc;
    bit stall_ok;
    bit seen;
    cyc = 0;
    stall_ok = 1'b1;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      if (DoneE === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (StallE !== 1'b1) stall_ok = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    check({tag, " done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " stall_before_done"}, {31'd0, stall_ok}, 32'd1);
    check({tag, " stall_in_done"}, {31'd0, StallE}, 32'd0);
    check({tag, " result"}, MulDivResultE, exp_res);
  endtask

  initial begin
    bit ok;
    rst    = 1'b0;
    StartE = 1'b0;
    OpE    = 2'b00;
    SrcAE  = 32'h0;
    SrcBE  = 32'h0;
    FlushE = 1'b0;

    #12;
    check("reset StallE", {31'd0, StallE}, 32'd0);
    check("reset DoneE", {31'd0, DoneE}, 32'd0);
    check("reset result", MulDivResultE, 32'h0);
    check("reset state", {30'd0, dut.state}, 32'd0);
    rst = 1'b1;

    // Back-to-back sequence: each start lands in the cycle right after DONE.
    start_op(OP_MUL, 32'd7, 32'd6);
    wait_done("mul_7x6", 32'h0000_002A, 33);
    start_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulhu_max", 32'hFFFF_FFFE, 33);
    start_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mul_max", 32'h0000_0001, 33);
    start_op(OP_DIVU, 32'd100, 32'd7);
    wait_done("divu_100_7", 32'h0000_000E, 33);
    start_op(OP_REMU, 32'd100, 32'd7);
    wait_done("remu_100_7", 32'h0000_0002, 33);
    start_op(OP_DIVU, 32'd5, 32'd9);
    wait_done("divu_5_9", 32'h0000_0000, 33);
    start_op(OP_REMU, 32'd5, 32'd9);
    wait_done("remu_5_9", 32'h0000_0005, 33);
    start_op(OP_DIVU, 32'h0000_1234, 32'd0);
    wait_done("divu_by0", 32'hFFFF_FFFF, 1);
    start_op(OP_REMU, 32'h0000_1234, 32'd0);
    wait_done("remu_by0", 32'h0000_1234, 1);

    // Flush at T+10 of a MUL; a fresh MUL 3x3 accepted at T+11 finishes at T+44.
    start_op(OP_MUL, 32'd7, 32'd6);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (StallE !== 1'b1 || DoneE !== 1'b0) ok = 1'b0;
      @(posedge clk);
      #1;
    end
    check("flush pre stall", {31'd0, ok}, 32'd1);
    FlushE = 1'b1;
    @(negedge clk);
    check("flush StallE", {31'd0, StallE}, 32'd0);
    check("flush DoneE", {31'd0, DoneE}, 32'd0);
    @(posedge clk);
    #1;
    check("flush state idle", {30'd0, dut.state}, 32'd0);
    FlushE = 1'b0;
    OpE    = OP_MUL;
    SrcAE  = 32'd3;
    SrcBE  = 32'd3;
    wait_done("mul_3x3_after_flush", 32'h0000_0009, 33);

    // Asynchronous reset at T+20 of a DIVU, with StartE still asserted.
    start_op(OP_DIVU, 32'd100, 32'd7);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
    end
    check("pre reset StallE", {31'd0, StallE}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid reset StallE", {31'd0, StallE}, 32'd0);
    check("mid reset DoneE", {31'd0, DoneE}, 32'd0);
    check("mid reset result", MulDivResultE, 32'h0);
    StartE = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    start_op(OP_DIVU, 32'd9, 32'd3);
    wait_done("divu_9_3_after_reset", 32'h0000_0003, 33);

    @(posedge clk);
    #1;
    StartE = 1'b0;
    @(negedge clk);
    check("final DoneE single pulse", {31'd0, DoneE}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
